fwd_ctrl: RTL and testbench

- Forwarding and hazard control unit for the 5-stage pipeline.
- Sits directly upstream of the EX-stage operand muxes and generates their 2-bit select inputs (per-bit 4:1 muxes, one bank for operand A and one for operand B).
- Keeps its own shadow pipeline of destination-register info (EX, MEM, WB slots).
- Detects load-use hazards and issues a one-cycle stall.

---
 rtl/fwd_pkg.sv | 37 +++
 rtl/fwd_match.sv | 32 +++
 rtl/fwd_ctrl.sv | 127 ++++++++++++
 tb/tb_fwd_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding/hazard control unit.
// Statistics are enabled by defining FWD_STATS_EN (see fwd_ctrl).
package fwd_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] ZR_ADDR = 5'd31;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10,
        FWD_ZERO  = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
    } pipe_slot_t;

    localparam pipe_slot_t SLOT_BUBBLE = '{1'b0, 5'd0, 1'b0, 1'b0};

    // A slot produces a forwardable result only if it really writes a non-zero register.
    function automatic logic slot_writing(input pipe_slot_t s);
        return s.valid & s.reg_write & (s.rd != ZR_ADDR);
    endfunction

    function automatic logic is_fwd(input fwd_sel_e s);
        return (s == FWD_EXMEM) || (s == FWD_MEMWB);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Operand mux select for one EX operand, from the ID source and the EX/MEM slots.
module fwd_match
    import fwd_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             used,
    input  pipe_slot_t       ex_slot,
    input  pipe_slot_t       mem_slot,
    output fwd_sel_e         sel
);

    // Load/ALU distinction does not affect which stage the value is taken from.
    logic unused_s;
    assign unused_s = ex_slot.mem_read ^ mem_slot.mem_read;

    // Priority chain: unused, zero register, newest producer (EX) before older (MEM).
    always_comb begin
        sel = FWD_RF;
        if (!used) begin
            sel = FWD_RF;
        end else if (src == ZR_ADDR) begin
            sel = FWD_ZERO;
        end else if (slot_writing(ex_slot) && (ex_slot.rd == src)) begin
            sel = FWD_EXMEM;
        end else if (slot_writing(mem_slot) && (mem_slot.rd == src)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding select and load-use stall generation for the 5-stage pipeline.
// Define FWD_STATS_EN to add saturating fwd_count / stall_count outputs.
module fwd_ctrl
    import fwd_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_rn_used,
    input  logic             id_rm_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
`ifdef FWD_STATS_EN
    output logic [15:0]      fwd_count,
    output logic [15:0]      stall_count,
`endif
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall
);

    pipe_slot_t ex_slot_r;
    pipe_slot_t mem_slot_r;
    pipe_slot_t wb_slot_r;
    pipe_slot_t id_slot_s;
    fwd_sel_e   sel_a_s;
    fwd_sel_e   sel_b_s;
    fwd_sel_e   sel_a_r;
    fwd_sel_e   sel_b_r;
    logic       stall_s;
    logic       bubble_s;

    // wb_slot only completes the shadow pipeline; WB hazards resolve in the regfile.
    logic unused_wb_s;
    assign unused_wb_s = ^wb_slot_r;

    assign id_slot_s = '{id_valid, id_rd, id_reg_write, id_mem_read};

    fwd_match u_match_a (
        .src      (id_rn),
        .used     (id_rn_used),
        .ex_slot  (ex_slot_r),
        .mem_slot (mem_slot_r),
        .sel      (sel_a_s)
    );

    fwd_match u_match_b (
        .src      (id_rm),
        .used     (id_rm_used),
        .ex_slot  (ex_slot_r),
        .mem_slot (mem_slot_r),
        .sel      (sel_b_s)
    );

    // Load-use detection; flush masks the stall, and a zero-register rd never writes.
    always_comb begin
        stall_s = 1'b0;
        if (id_valid && !flush && slot_writing(ex_slot_r) && ex_slot_r.mem_read) begin
            stall_s = (id_rn_used && (id_rn == ex_slot_r.rd)) ||
                      (id_rm_used && (id_rm == ex_slot_r.rd));
        end else begin
            stall_s = 1'b0;
        end
    end

    assign bubble_s  = flush | stall_s;
    assign stall     = stall_s;
    assign fwd_a_sel = sel_a_r;
    assign fwd_b_sel = sel_b_r;

    // Shadow pipeline advance and registered operand selects.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_slot_r  <= SLOT_BUBBLE;
            mem_slot_r <= SLOT_BUBBLE;
            wb_slot_r  <= SLOT_BUBBLE;
            sel_a_r    <= FWD_RF;
            sel_b_r    <= FWD_RF;
        end else begin
            mem_slot_r <= ex_slot_r;
            wb_slot_r  <= mem_slot_r;
            if (bubble_s) begin
                ex_slot_r <= SLOT_BUBBLE;
                sel_a_r   <= FWD_RF;
                sel_b_r   <= FWD_RF;
            end else begin
                ex_slot_r <= id_slot_s;
                sel_a_r   <= sel_a_s;
                sel_b_r   <= sel_b_s;
            end
        end
    end

`ifdef FWD_STATS_EN
    logic       fwd_event_s;
    logic [15:0] fwd_count_r;
    logic [15:0] stall_count_r;

    assign fwd_event_s = !bubble_s && (is_fwd(sel_a_s) || is_fwd(sel_b_s));
    assign fwd_count   = fwd_count_r;
    assign stall_count = stall_count_r;

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fwd_count_r   <= 16'd0;
            stall_count_r <= 16'd0;
        end else begin
            if (fwd_event_s) begin
                fwd_count_r <= sat_inc(fwd_count_r);
            end else begin
                fwd_count_r <= fwd_count_r;
            end
            if (stall_s) begin
                stall_count_r <= sat_inc(stall_count_r);
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed bench for fwd_ctrl: forwarding, double match, load-use, zero register, flush, reset.
module tb_fwd_ctrl;
    import fwd_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             id_valid;
    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rm;
    logic             id_rn_used;
    logic             id_rm_used;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             flush;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             stall;
`ifdef FWD_STATS_EN
    logic [15:0]      fwd_count;
    logic [15:0]      stall_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    fwd_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .id_valid     (id_valid),
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .id_rn_used   (id_rn_used),
        .id_rm_used   (id_rm_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
`ifdef FWD_STATS_EN
        .fwd_count    (fwd_count),
        .stall_count  (stall_count),
`endif
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // v, rn, rn_used, rm, rm_used, rd, reg_write, mem_read
    task automatic drive(input logic v, input logic [4:0] rn, input logic rnu,
                         input logic [4:0] rm, input logic rmu, input logic [4:0] rd,
                         input logic rw, input logic mr);
        id_valid = v; id_rn = rn; id_rn_used = rnu; id_rm = rm; id_rm_used = rmu;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_sels(input string tag, input logic [1:0] ea, input logic [1:0] eb);
        check({tag, "_sel_a"}, {14'd0, fwd_a_sel}, {14'd0, ea});
        check({tag, "_sel_b"}, {14'd0, fwd_b_sel}, {14'd0, eb});
    endtask

    initial begin
        reset_n = 1'b0;
        flush = 1'b0;
        nop();
        #1;
        check_sels("reset", 2'b00, 2'b00);
        check("reset_stall", {15'd0, stall}, 16'd0);
        step();
        step();
        reset_n = 1'b1;

        // EX/MEM forwarding: ADD X1,X2,X3 ; SUB X2,X1,X4
        drive(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0);
        step();
        check_sels("add_first", 2'b00, 2'b00);
        drive(1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 5'd2, 1'b1, 1'b0);
        #1;
        check("sub_stall", {15'd0, stall}, 16'd0);
        step();
        check_sels("exmem_fwd", 2'b01, 2'b00);

        // Double match: ADD X1 ; ADD X1 ; ORR X5,X1,X1 -> newest (EX) wins
        drive(1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0);
        step();
        check_sels("double_match", 2'b01, 2'b01);

        // ADD X1 ; NOP ; ORR X5,X1,X1 -> MEM/WB
        drive(1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 1'b0);
        step();
        nop();
        step();
        drive(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0);
        step();
        check_sels("memwb_fwd", 2'b10, 2'b10);

        // Load-use: LDUR X7,[X2] ; ADD X8,X7,X2
        drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        step();
        check_sels("ldur", 2'b00, 2'b00);
        drive(1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0);
        #1;
        check("loaduse_stall", {15'd0, stall}, 16'd1);
        step();
        check_sels("loaduse_bubble", 2'b00, 2'b00);
        check("loaduse_stall_clear", {15'd0, stall}, 16'd0);
        step();
        check_sels("loaduse_after", 2'b10, 2'b00);

        // Zero register: ADD X31 ; AND X9,X31,X31
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd31, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 5'd9, 1'b1, 1'b0);
        #1;
        check("zr_add_stall", {15'd0, stall}, 16'd0);
        step();
        check_sels("zr_and", 2'b11, 2'b11);

        // LDUR X31 ; ADD X10,X31,X4 -> zero, no stall
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd31, 1'b1, 1'b1);
        step();
        drive(1'b1, 5'd31, 1'b1, 5'd4, 1'b1, 5'd10, 1'b1, 1'b0);
        #1;
        check("zr_ldur_stall", {15'd0, stall}, 16'd0);
        step();
        check_sels("zr_ldur_use", 2'b11, 2'b00);

        // Flush on a load-use: LDUR X12 ; ADD X13,X12,X12 (flushed) ; ADD X14,X12,X13
        drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
        step();
        drive(1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 5'd13, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        check("flush_stall_masked", {15'd0, stall}, 16'd0);
        step();
        check_sels("flush_bubble", 2'b00, 2'b00);
        flush = 1'b0;
        drive(1'b1, 5'd12, 1'b1, 5'd13, 1'b1, 5'd14, 1'b1, 1'b0);
        #1;
        check("post_flush_stall", {15'd0, stall}, 16'd0);
        step();
        check_sels("post_flush", 2'b10, 2'b00);

        // Mid-stream reset: ADD X3 ; LDUR X3,[X3] ; ADD X9,X3,X3 with reset asserted
        drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
        step();
        check_sels("ldur_fwd", 2'b01, 2'b00);
`ifdef FWD_STATS_EN
        check("fwd_count", fwd_count, 16'd6);
        check("stall_count", stall_count, 16'd1);
`endif
        drive(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0);
        #1;
        check("pre_reset_stall", {15'd0, stall}, 16'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("midreset_stall", {15'd0, stall}, 16'd0);
        check_sels("midreset", 2'b00, 2'b00);
`ifdef FWD_STATS_EN
        check("midreset_fwd_count", fwd_count, 16'd0);
        check("midreset_stall_count", stall_count, 16'd0);
`endif
        step();
        reset_n = 1'b1;
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        step();
        check_sels("post_reset", 2'b00, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
